// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the signals between the memory arbiter and its surroundings.
//   Fetch side : IReq, IAddr in; IRData, IAck out
//   Data side  : DReq, DWe, DAddr, DWData in; DRData, DAck out
//   Hazard     : StallMemF, StallMemM out
//   Memory     : MemValid, MemWe, MemAddr, MemWData out; MemReady, MemRData in
// The slave modport is the arbiter's view.
// The master modport is the view of everything around it: the pipeline stages and the memory.
interface mem_arbiter_if;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRData;
    logic        IAck;
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic [31:0] DRData;
    logic        DAck;
    logic        StallMemF;
    logic        StallMemM;
    logic        MemValid;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemReady;
    logic [31:0] MemRData;

    modport slave (
        input  IReq, IAddr, DReq, DWe, DAddr, DWData, MemReady, MemRData,
        output IRData, IAck, DRData, DAck, StallMemF, StallMemM,
               MemValid, MemWe, MemAddr, MemWData
    );

    modport master (
        output IReq, IAddr, DReq, DWe, DAddr, DWData, MemReady, MemRData,
        input  IRData, IAck, DRData, DAck, StallMemF, StallMemM,
               MemValid, MemWe, MemAddr, MemWData
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one word-wide memory port between instruction fetch and the memory stage.
// Each access runs through a valid/ready handshake with the memory.
// Per-stage stalls are reported to the hazard unit.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : mem_arbiter_if.slave, which carries the fetch, data, stall and memory port signals
// All memory-side outputs, acks and read data are registered.
// Only the two stall outputs are combinational, from Req and the registered Ack.
module mem_arbiter (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t state;
    logic   last_grant;   // 0 = fetch served last, 1 = data served last

    logic fetch_elig;
    logic data_elig;
    logic grant_data;
    logic grant_fetch;

    // A request whose Ack is pulsing this cycle is already complete, even if Req is still high.
    // Masking it with the Ack prevents a duplicate access.
    assign fetch_elig  = bus.IReq & ~bus.IAck;
    assign data_elig   = bus.DReq & ~bus.DAck;

    // On a tie, the requester that was not served last wins.
    // last_grant resets to 0, so data wins the first tie.
    assign grant_data  = data_elig & (~fetch_elig | ~last_grant);
    assign grant_fetch = fetch_elig & ~grant_data;

    assign bus.StallMemF = bus.IReq & ~bus.IAck;
    assign bus.StallMemM = bus.DReq & ~bus.DAck;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b0;
            bus.MemValid <= 1'b0;
            bus.MemWe    <= 1'b0;
            bus.MemAddr  <= '0;
            bus.MemWData <= '0;
            bus.IAck     <= 1'b0;
            bus.DAck     <= 1'b0;
            bus.IRData   <= '0;
            bus.DRData   <= '0;
        end else begin
            bus.IAck <= 1'b0;
            bus.DAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state        <= BUSY_D;
                        bus.MemValid <= 1'b1;
                        bus.MemWe    <= bus.DWe;
                        bus.MemAddr  <= bus.DAddr;
                        bus.MemWData <= bus.DWData;
                    end else if (grant_fetch) begin
                        state        <= BUSY_I;
                        bus.MemValid <= 1'b1;
                        bus.MemWe    <= 1'b0;
                        bus.MemAddr  <= bus.IAddr;
                        bus.MemWData <= '0;
                    end
                end
                BUSY_I: begin
                    if (bus.MemReady) begin
                        state        <= IDLE;
                        bus.MemValid <= 1'b0;
                        bus.MemWe    <= 1'b0;
                        bus.IAck     <= 1'b1;
                        bus.IRData   <= bus.MemRData;
                        last_grant   <= 1'b0;
                    end
                end
                BUSY_D: begin
                    if (bus.MemReady) begin
                        state        <= IDLE;
                        bus.MemValid <= 1'b0;
                        bus.MemWe    <= 1'b0;
                        bus.DAck     <= 1'b1;
                        // Stores leave the last load result in DRData.
                        if (!bus.MemWe) begin
                            bus.DRData <= bus.MemRData;
                        end
                        last_grant   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the combined ARM/RISC-V pipeline. It shares one unified word-wide memory port between the fetch stage (instruction reads at PCF) and the memory stage (data loads/stores). It sequences each access through a valid/ready handshake and reports per-stage stalls to the hazard unit. The hazard unit ORs these stalls into StallF/StallD and the memory-stage stall.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  system clock, single clock domain
- rst  in  1  reset; synchronous, active-high
- IReq  in  1  fetch request; held high with IAddr stable until IAck
- IAddr  in  32  fetch address (PCF)
- IRData  out  32  fetched instruction; valid in the IAck cycle, held afterwards
- IAck  out  1  one-cycle pulse: fetch complete
- DReq  in  1  data request; held high with DAddr/DWData/DWe stable until DAck
- DWe  in  1  1 = store, 0 = load
- DAddr  in  32  data address (ALUResultM)
- DWData  in  32  store data (WriteDataM)
- DRData  out  32  load data; valid in the DAck cycle, held afterwards
- DAck  out  1  one-cycle pulse: data access complete
- StallMemF  out  1  = IReq & ~IAck (combinational)
- StallMemM  out  1  = DReq & ~DAck (combinational)
- MemValid  out  1  request to memory, registered
- MemWe  out  1  write enable, registered
- MemAddr  out  32  memory address, registered
- MemWData  out  32  memory write data, registered
- MemReady  in  1  memory accepts/completes the transfer in this cycle
- MemRData  in  32  read data; valid when MemValid & MemReady

## Operation
- States: IDLE, BUSY_I, BUSY_D. A 1-bit LastGrant records the last-served requester (0 = fetch, 1 = data).
- Eligibility in IDLE:
  - A requester is eligible when its Req is high and its own Ack is low in that cycle.
  - This blocks re-issue of a just-completed request whose Req has not yet dropped.
- Arbitration in IDLE:
  - Only DReq eligible → BUSY_D.
  - Only IReq eligible → BUSY_I.
  - Both eligible → grant the requester not equal to LastGrant (round-robin).
  - Neither eligible → stay in IDLE.
- On grant:
  - Latch address, plus DWe/DWData for data, into MemAddr/MemWe/MemWData.
  - Set MemValid.
  - Fetch grants force MemWe = 0 and MemWData = 0.
- BUSY_x with MemReady = 0: hold all Mem* outputs unchanged; wait indefinitely.
- BUSY_x with MemReady = 1, on the next edge:
  - Clear MemValid and MemWe.
  - Pulse the matching Ack for one cycle.
  - Update LastGrant.
  - Return to IDLE.
  - Load IRData from MemRData for fetch, or DRData from MemRData for data loads. On stores DRData holds its previous value.
- Inputs changing while BUSY do not affect the in-flight access.
- A request dropped before its Ack leaves the in-flight access to complete. Its Ack still pulses and is ignored by the pipeline.
- Arbiter never splits or merges accesses; word accesses only, address passed through unmodified.

## Timing
- Reset, synchronous, overrides everything including an in-flight access:
  - State = IDLE, LastGrant = 0, so data wins the first tie.
  - MemValid = 0, MemWe = 0, MemAddr = 0, MemWData = 0.
  - IAck = 0, DAck = 0, IRData = 0, DRData = 0.
  - A memory mid-transaction must tolerate the withdrawn MemValid.
- Request eligible in IDLE at cycle n → MemValid high from cycle n+1.
- MemReady sampled high at cycle n+1+k → Ack and read data at cycle n+2+k. Minimum latency is 2 cycles.
- Ack cycle (state IDLE): the other requester may be granted in the same cycle. MemValid is low for exactly one cycle between back-to-back accesses.
- Stall outputs are combinational from registered Ack and the input Req. There is no combinational path from MemReady to any output.

## Test plan
- Single fetch: IReq = 1, IAddr = 0x100, MemReady = 1 immediately, MemRData = 0xDEADBEEF.
  - Required: MemValid in cycle 1 with MemAddr = 0x100.
  - IAck and IRData = 0xDEADBEEF in cycle 2; StallMemF high in cycles 0–1, low in cycle 2.
- Store with wait states: DReq = 1, DWe = 1, DAddr = 0x40, DWData = 0x12345678, MemReady low for 3 cycles.
  - Required: Mem* held stable for 4 cycles; DAck one cycle later; DRData unchanged.
- Simultaneous requests after reset: IReq and DReq both high and held.
  - Required: data served first, then fetch granted in the DAck cycle.
  - Continuing with IReq held and a new DReq presented in the IAck cycle: fetch served, then data, alternating; no requester served twice in a row while the other waits.
- Held request after Ack: IReq stays high with the same IAddr for one cycle past IAck.
  - Required: no second MemValid for that address in the IAck cycle.
- Reset mid-access: assert rst while in BUSY_D with MemReady = 0.
  - Required: next cycle MemValid = 0, DAck = 0, DRData = 0, and all other outputs at reset values.
  - Subsequent IReq gets normal 2-cycle service.
